// File: rtl/arbitro_escrita_reg.sv
`default_nettype none
// ============================================================================
// Module      : arbitro_escrita_reg
// Description : Register-file write-port arbiter.
//
//               The primary writer (datapath writeback) always wins and is
//               forwarded with zero latency. Secondary writes (long-latency
//               unit) are queued in a 2-entry FIFO. They drain whenever the
//               primary is idle.
//
//               If the primary keeps the port busy for LIMITE_ESPERA
//               consecutive cycles while an entry waits, a one-cycle
//               processor stall is forced. During that stall the FIFO head
//               is written.
//
// Parameters  : LIMITE_ESPERA    blocked cycles before a forced stall (1..15)
//
// Ports       : clock, reset     clock / asynchronous active-high reset
//               mux_REGISTRADOR  primary address select (1 = R[t], 2 = R[d])
//               endereco_2/3     R[t] / R[d] addresses
//               escreve_principal, dado_principal   primary write request
//               sec_valido, sec_endereco, sec_dado  secondary write request
//               sec_pronto       secondary request accepted this cycle
//               reg_escreve, endereco_escrita, dado_escrita  write port
//               parar_processador  one-cycle datapath stall request
//               cont_escritas_sec, cont_paradas  (only with the macro below)
//
// Options     : define ARBITRO_ESCRITA_CONTADORES_EN to add the saturating
//               secondary-write and stall-cycle counters.
//
// Revision    : 1.0  initial release
// ============================================================================
module arbitro_escrita_reg #(
    parameter int LIMITE_ESPERA = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  mux_REGISTRADOR,
    input  logic [4:0]  endereco_2,
    input  logic [4:0]  endereco_3,
    input  logic        escreve_principal,
    input  logic [31:0] dado_principal,
    input  logic        sec_valido,
    input  logic [4:0]  sec_endereco,
    input  logic [31:0] sec_dado,
    output logic        sec_pronto,
    output logic        reg_escreve,
    output logic [4:0]  endereco_escrita,
    output logic [31:0] dado_escrita,
`ifdef ARBITRO_ESCRITA_CONTADORES_EN
    output logic        parar_processador,
    output logic [15:0] cont_escritas_sec,
    output logic [15:0] cont_paradas
`else
    output logic        parar_processador
`endif
);

    localparam logic [1:0] OCIOSO   = 2'd0;
    localparam logic [1:0] PENDENTE = 2'd1;
    localparam logic [1:0] PARADA   = 2'd2;

    localparam logic [3:0] LIMITE_C = 4'(LIMITE_ESPERA);

    // FIFO storage: 2-entry ring buffer.
    logic [4:0]  fifo_end_q  [0:1];
    logic [31:0] fifo_dado_q [0:1];
    logic        ptr_rd_q, ptr_wr_q;
    logic [1:0]  ocupacao_q, ocupacao_d;

    logic [1:0]  estado_q, estado_d;
    logic [3:0]  espera_q, espera_d;

    // Cleared by reset, set on the first edge afterwards. This keeps
    // sec_pronto low until the arbiter has seen a clock out of reset.
    logic        pronto_q;

    logic [4:0]  end_principal;
    logic        principal_ativo;
    logic        push, pop;

    // ------------------------------------------------------------------
    // Primary request decode
    // ------------------------------------------------------------------
    always_comb begin
        end_principal = 5'd0;
        case (mux_REGISTRADOR)
            2'd1:    end_principal = endereco_2;
            2'd2:    end_principal = endereco_3;
            default: end_principal = 5'd0;
        endcase
    end

    // A zero address selects nothing, which also covers mux values 0 and 3.
    // The primary is masked during the forced stall.
    assign principal_ativo = escreve_principal && (end_principal != 5'd0)
                             && (estado_q != PARADA);

    assign parar_processador = (estado_q == PARADA);

    // Ready depends only on registered occupancy. A pop in the same cycle
    // therefore cannot reopen a full FIFO.
    assign sec_pronto = pronto_q && (ocupacao_q != 2'd2);

    // A request to address 0 completes the handshake but is never stored.
    assign push = sec_valido && sec_pronto && (sec_endereco != 5'd0);
    assign pop  = (ocupacao_q != 2'd0) && !principal_ativo;

    // ------------------------------------------------------------------
    // Write port (combinational, forced to 0 while reset is asserted)
    // ------------------------------------------------------------------
    always_comb begin
        reg_escreve      = 1'b0;
        endereco_escrita = 5'd0;
        dado_escrita     = 32'd0;
        if (!reset) begin
            if (principal_ativo) begin
                reg_escreve      = 1'b1;
                endereco_escrita = end_principal;
                dado_escrita     = dado_principal;
            end else if (ocupacao_q != 2'd0) begin
                reg_escreve      = 1'b1;
                endereco_escrita = fifo_end_q[ptr_rd_q];
                dado_escrita     = fifo_dado_q[ptr_rd_q];
            end
        end
    end

    // ------------------------------------------------------------------
    // Occupancy and state machine next-state
    // ------------------------------------------------------------------
    always_comb begin
        ocupacao_d = ocupacao_q;
        case ({push, pop})
            2'b10:   ocupacao_d = ocupacao_q + 2'd1;
            2'b01:   ocupacao_d = ocupacao_q - 2'd1;
            default: ocupacao_d = ocupacao_q;
        endcase
    end

    always_comb begin
        estado_d = estado_q;
        espera_d = espera_q;
        case (estado_q)
            OCIOSO: begin
                espera_d = 4'd0;
                if (push)
                    estado_d = PENDENTE;
            end
            PENDENTE: begin
                if (pop) begin
                    espera_d = 4'd0;
                    if (ocupacao_d == 2'd0)
                        estado_d = OCIOSO;
                end else if (principal_ativo) begin
                    espera_d = espera_q + 4'd1;
                    // Stall on the edge where the count reaches the limit.
                    if (espera_d >= LIMITE_C)
                        estado_d = PARADA;
                end
            end
            PARADA: begin
                espera_d = 4'd0;
                estado_d = (ocupacao_d != 2'd0) ? PENDENTE : OCIOSO;
            end
            default: begin
                espera_d = 4'd0;
                estado_d = OCIOSO;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fifo_end_q[0]  <= 5'd0;
            fifo_end_q[1]  <= 5'd0;
            fifo_dado_q[0] <= 32'd0;
            fifo_dado_q[1] <= 32'd0;
            ptr_rd_q       <= 1'b0;
            ptr_wr_q       <= 1'b0;
            ocupacao_q     <= 2'd0;
            estado_q       <= OCIOSO;
            espera_q       <= 4'd0;
            pronto_q       <= 1'b0;
        end else begin
            pronto_q   <= 1'b1;
            ocupacao_q <= ocupacao_d;
            estado_q   <= estado_d;
            espera_q   <= espera_d;
            if (push) begin
                fifo_end_q[ptr_wr_q]  <= sec_endereco;
                fifo_dado_q[ptr_wr_q] <= sec_dado;
                ptr_wr_q              <= ptr_wr_q + 1'b1;
            end
            if (pop)
                ptr_rd_q <= ptr_rd_q + 1'b1;
        end
    end

`ifdef ARBITRO_ESCRITA_CONTADORES_EN
    logic [15:0] cont_sec_q, cont_par_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cont_sec_q <= 16'd0;
            cont_par_q <= 16'd0;
        end else begin
            if (pop && (cont_sec_q != 16'hFFFF))
                cont_sec_q <= cont_sec_q + 16'd1;
            if ((estado_q == PARADA) && (cont_par_q != 16'hFFFF))
                cont_par_q <= cont_par_q + 16'd1;
        end
    end

    assign cont_escritas_sec = cont_sec_q;
    assign cont_paradas      = cont_par_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_arbitro_escrita_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_arbitro_escrita_reg
// Description : Directed self-checking bench for arbitro_escrita_reg.
//               It covers primary pass-through, secondary drain, the full
//               FIFO, starvation stall, address-0 discard and mid-run reset.
// Revision    : 1.0  initial release
// ============================================================================
module tb_arbitro_escrita_reg;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  mux_REGISTRADOR;
    logic [4:0]  endereco_2, endereco_3;
    logic        escreve_principal;
    logic [31:0] dado_principal;
    logic        sec_valido;
    logic [4:0]  sec_endereco;
    logic [31:0] sec_dado;
    logic        sec_pronto;
    logic        reg_escreve;
    logic [4:0]  endereco_escrita;
    logic [31:0] dado_escrita;
    logic        parar_processador;

    int total = 0;
    int bad   = 0;

    arbitro_escrita_reg #(.LIMITE_ESPERA(4)) dut (
        .clock             (clock),
        .reset             (reset),
        .mux_REGISTRADOR   (mux_REGISTRADOR),
        .endereco_2        (endereco_2),
        .endereco_3        (endereco_3),
        .escreve_principal (escreve_principal),
        .dado_principal    (dado_principal),
        .sec_valido        (sec_valido),
        .sec_endereco      (sec_endereco),
        .sec_dado          (sec_dado),
        .sec_pronto        (sec_pronto),
        .reg_escreve       (reg_escreve),
        .endereco_escrita  (endereco_escrita),
        .dado_escrita      (dado_escrita),
        .parar_processador (parar_processador)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and leave 1 time unit for outputs to settle.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Check the full write port plus the stall flag.
    task automatic chk_port(input string tag, input logic we, input logic [4:0] a,
                            input logic [31:0] d, input logic st);
        #1;
        chk({tag, ".we"},   {31'd0, reg_escreve}, {31'd0, we});
        chk({tag, ".addr"}, {27'd0, endereco_escrita}, {27'd0, a});
        chk({tag, ".data"}, dado_escrita, d);
        chk({tag, ".stall"}, {31'd0, parar_processador}, {31'd0, st});
    endtask

    task automatic prim(input logic en, input logic [1:0] m, input logic [31:0] d);
        escreve_principal = en;
        mux_REGISTRADOR   = m;
        dado_principal    = d;
    endtask

    task automatic sec(input logic v, input logic [4:0] a, input logic [31:0] d);
        sec_valido   = v;
        sec_endereco = a;
        sec_dado     = d;
    endtask

    initial begin
        reset = 1'b1;
        endereco_2 = 5'd7;
        endereco_3 = 5'd9;
        prim(1'b1, 2'd2, 32'h1234);
        sec(1'b1, 5'd5, 32'hAA);
        #2;
        // Outputs must be quiet while reset is held, even with requests present.
        chk_port("rst", 1'b0, 5'd0, 32'd0, 1'b0);
        chk("rst.pronto", {31'd0, sec_pronto}, 32'd0);
        tick(); tick();
        sec(1'b0, 5'd0, 32'd0);
        prim(1'b0, 2'd0, 32'd0);
        reset = 1'b0;
        tick();
        chk("rel.pronto", {31'd0, sec_pronto}, 32'd1);

        // Primary pass-through, zero latency.
        prim(1'b1, 2'd2, 32'h1234);
        chk_port("prim_rd", 1'b1, 5'd9, 32'h1234, 1'b0);
        prim(1'b1, 2'd1, 32'h5678);
        chk_port("prim_rt", 1'b1, 5'd7, 32'h5678, 1'b0);
        prim(1'b1, 2'd0, 32'h1234);
        chk_port("prim_mux0", 1'b0, 5'd0, 32'd0, 1'b0);
        prim(1'b1, 2'd3, 32'h1234);
        chk_port("prim_mux3", 1'b0, 5'd0, 32'd0, 1'b0);
        prim(1'b0, 2'd0, 32'd0);

        // Secondary with the primary idle: written one cycle later.
        sec(1'b1, 5'd5, 32'hAA);
        chk_port("sec_c0", 1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        sec(1'b0, 5'd0, 32'd0);
        chk_port("sec_c1", 1'b1, 5'd5, 32'hAA, 1'b0);
        tick();
        chk_port("sec_c2", 1'b0, 5'd0, 32'd0, 1'b0);

        // Full FIFO while the primary holds the port.
        prim(1'b1, 2'd1, 32'h55);
        sec(1'b1, 5'd3, 32'h33);
        tick();
        sec(1'b1, 5'd4, 32'h44);
        #1 chk("full.pronto1", {31'd0, sec_pronto}, 32'd1);
        chk_port("full.prim", 1'b1, 5'd7, 32'h55, 1'b0);
        tick();
        chk("full.pronto0", {31'd0, sec_pronto}, 32'd0);
        sec(1'b0, 5'd0, 32'd0);
        prim(1'b0, 2'd0, 32'd0);
        chk_port("full.w3", 1'b1, 5'd3, 32'h33, 1'b0);
        tick();
        chk_port("full.w4", 1'b1, 5'd4, 32'h44, 1'b0);
        tick();
        chk_port("full.empty", 1'b0, 5'd0, 32'd0, 1'b0);

        // Starvation: 4 blocked cycles, then one stall cycle writes the entry.
        prim(1'b1, 2'd1, 32'h77);
        sec(1'b1, 5'd12, 32'hC);
        tick();
        sec(1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk_port($sformatf("starv.blk%0d", i), 1'b1, 5'd7, 32'h77, 1'b0);
            tick();
        end
        chk_port("starv.stall", 1'b1, 5'd12, 32'hC, 1'b1);
        tick();
        chk_port("starv.after", 1'b1, 5'd7, 32'h77, 1'b0);
        prim(1'b0, 2'd0, 32'd0);

        // Address 0 is accepted but never written.
        sec(1'b1, 5'd0, 32'hFF);
        tick();
        sec(1'b0, 5'd0, 32'd0);
        chk_port("zero.c1", 1'b0, 5'd0, 32'd0, 1'b0);
        chk("zero.pronto", {31'd0, sec_pronto}, 32'd1);
        tick();
        chk_port("zero.c2", 1'b0, 5'd0, 32'd0, 1'b0);

        // Reset with two entries buffered.
        prim(1'b1, 2'd1, 32'h99);
        sec(1'b1, 5'd3, 32'h33);
        tick();
        sec(1'b1, 5'd4, 32'h44);
        tick();
        sec(1'b0, 5'd0, 32'd0);
        reset = 1'b1;
        chk_port("mrst.held", 1'b0, 5'd0, 32'd0, 1'b0);
        chk("mrst.pronto", {31'd0, sec_pronto}, 32'd0);
        tick();
        prim(1'b0, 2'd0, 32'd0);
        reset = 1'b0;
        chk_port("mrst.rel", 1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        chk_port("mrst.c1", 1'b0, 5'd0, 32'd0, 1'b0);
        chk("mrst.pronto1", {31'd0, sec_pronto}, 32'd1);
        tick();
        chk_port("mrst.c2", 1'b0, 5'd0, 32'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arbitro_escrita_reg.md
ARBITRO_ESCRITA_REG -- requirements
Module: arbitro_escrita_reg

Interface
REQ-001 Parameter LIMITE_ESPERA, default 4, SHALL set the number of consecutive blocked cycles before a forced stall (legal range 1..15).
REQ-002 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be asynchronous, active-high reset.
REQ-004 mux_REGISTRADOR  input  2  SHALL be the primary write-address select: 0 none, 1 R[t], 2 R[d], 3 none.
REQ-005 endereco_2  input  5  SHALL be the R[t] address; endereco_3  input  5  SHALL be the R[d] address.
REQ-006 escreve_principal  input  1  SHALL be the primary (datapath writeback) write enable; dado_principal  input  32  SHALL be its data.
REQ-007 sec_valido  input  1, sec_endereco  input  5, sec_dado  input  32  SHALL form the secondary (long-latency unit) write request.
REQ-008 sec_pronto  output  1  SHALL indicate the arbiter accepts a secondary request this cycle.
REQ-009 reg_escreve  output  1, endereco_escrita  output  5, dado_escrita  output  32  SHALL drive the register-file write port.
REQ-010 parar_processador  output  1  SHALL request a one-cycle datapath stall.

Function
REQ-011 Primary active SHALL mean escreve_principal=1, mux_REGISTRADOR in {1,2}, selected address nonzero, parar_processador=0.
REQ-012 Primary active SHALL drive the write port combinationally (0-cycle latency) with the selected address and dado_principal.
REQ-013 Secondary requests SHALL enter a 2-entry FIFO; handshake completes on a rising edge with sec_valido=1 and sec_pronto=1.
REQ-014 sec_pronto SHALL equal 1 when FIFO occupancy <2 (registered occupancy; a same-cycle pop does not raise it).
REQ-015 An accepted request with sec_endereco=0 SHALL be consumed and discarded (not enqueued).
REQ-016 When primary is not active and FIFO nonempty, the write port SHALL carry the FIFO head and the head SHALL pop at the next edge; secondary latency is therefore >=1 cycle.
REQ-017 Otherwise reg_escreve=0, endereco_escrita=0, dado_escrita=0.
REQ-018 Simultaneous push and pop SHALL keep occupancy unchanged and preserve FIFO order.
REQ-019 A primary write to an address held in the FIFO SHALL NOT cancel the entry; entries are written later in FIFO order.
REQ-020 State machine: OCIOSO (FIFO empty), PENDENTE (nonempty, waiting), PARADA (forced stall).
REQ-021 In PENDENTE, 4-bit counter espera SHALL increment each cycle primary is active, and clear on any pop.
REQ-022 PENDENTE->PARADA SHALL occur on the edge where espera reaches LIMITE_ESPERA; parar_processador=1 (registered) exactly while in PARADA.
REQ-023 In PARADA the primary SHALL be masked, the head SHALL be written and popped; PARADA lasts exactly one cycle, then ->PENDENTE if nonempty else OCIOSO, espera=0.
REQ-024 OCIOSO->PENDENTE on first enqueue; PENDENTE->OCIOSO when last entry pops without a push.

Reset
REQ-025 While reset=1: FIFO empty, espera=0, state OCIOSO, parar_processador=0, sec_pronto=0, reg_escreve=0, endereco_escrita=0, dado_escrita=0.
REQ-026 Reset asserted mid-operation SHALL discard all buffered entries immediately; sec_pronto=1 from the first edge after release.

Configuration
REQ-027 With macro ARBITRO_ESCRITA_CONTADORES_EN defined, outputs cont_escritas_sec (16, secondary writes performed) and cont_paradas (16, PARADA cycles) SHALL exist, saturate at 0xFFFF, and reset to 0.
REQ-028 Without ARBITRO_ESCRITA_CONTADORES_EN, those ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-029 Primary only: mux=2, endereco_3=9, dado=0x1234, escreve=1 -> same cycle reg_escreve=1, addr 9, data 0x1234; mux=0 -> reg_escreve=0.
REQ-030 Secondary idle: push addr 5 data 0xAA with primary idle -> next cycle write addr 5 data 0xAA, FIFO empty after.
REQ-031 Full: push addr 3, 4 while primary active -> sec_pronto=0; release primary -> writes 3 then 4 on consecutive cycles.
REQ-032 Starvation, LIMITE_ESPERA=4: one entry, primary active continuously -> parar_processador=1 for one cycle after 4 blocked cycles, entry written in that cycle, primary masked.
REQ-033 Zero/reset: push addr 0 -> never written; reset pulse with 2 entries buffered -> outputs 0 immediately, no buffered write after release.
